// File: rtl/conv_window_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_gen_pkg
// Description : Shared types and defaults for the 3x3 convolution window
//               generator: FSM encodings, default dimensions and the
//               frame-dimension legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_window_gen_pkg;

  localparam int CONV_DATA_WIDTH = 8;
  localparam int CONV_MAX_WIDTH  = 256;
  localparam int CONV_DIM_WIDTH  = 9;
  localparam int CONV_NUM_LINES  = 2;
  localparam int CONV_WIN_DIM    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // A 3x3 window needs at least three rows and three columns; the width is
  // further bounded by the line-buffer depth.
  function automatic logic dims_legal(input int unsigned w,
                                      input int unsigned h,
                                      input int unsigned max_w,
                                      input int unsigned max_h);
    return (w >= 32'd3) && (w <= max_w) && (h >= 32'd3) && (h <= max_h);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_window_gen_line_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer_ram
// Description : Cascaded line buffers, one simple dual-port RAM per line.
//               Line 0 stores the incoming pixel, line k stores what line
//               k-1 held at the same address (one row older). Synchronous
//               read; a read of the address being written returns old data.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_LINES  = 2
) (
  input  logic                                 clk,
  input  logic                                 we_i,
  input  logic [ADDR_WIDTH-1:0]                waddr_i,
  input  logic [DATA_WIDTH-1:0]                wdata_i,
  input  logic [ADDR_WIDTH-1:0]                raddr_i,
  output logic [NUM_LINES-1:0][DATA_WIDTH-1:0] rdata_o
);

  logic [NUM_LINES-1:0][DATA_WIDTH-1:0] wline;

  // Line k is written with the registered read data of line k-1, which the
  // caller has prefetched from the same address one cycle earlier.
  if (NUM_LINES > 1) begin : g_cascade
    assign wline = {rdata_o[NUM_LINES-2:0], wdata_i};
  end else begin : g_single
    assign wline = wdata_i;
  end

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    // Storage is deliberately not reset; old-data read-during-write falls out of NBA ordering.
    always_ff @(posedge clk) begin
      if (we_i) begin
        mem_q[waddr_i] <= wline[g];
      end
      rd_q <= mem_q[raddr_i];
    end

    assign rdata_o[g] = rd_q;
  end

endmodule
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_gen
// Description : Raster-order pixel stream to 3x3 sliding window generator
//               (valid-only windows, no padding) with a registered,
//               back-pressured window output.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int DATA_WIDTH = CONV_DATA_WIDTH,
  parameter int MAX_WIDTH  = CONV_MAX_WIDTH,
  parameter int DIM_WIDTH  = CONV_DIM_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic [DIM_WIDTH-1:0]    img_width,
  input  logic [DIM_WIDTH-1:0]    img_height,
  input  logic [DATA_WIDTH-1:0]   pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  output logic [9*DATA_WIDTH-1:0] MAC_data_in,
  output logic                    MAC_data_valid_in,
  input  logic                    win_ready,
  output logic                    frame_done,
  output logic                    cfg_err
);

  localparam int ADDR_WIDTH = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int WIN_DIM    = CONV_WIN_DIM;
  localparam int NUM_LINES  = CONV_NUM_LINES;
  localparam logic [DIM_WIDTH-1:0] DIM_ONE = DIM_WIDTH'(1);
  localparam logic [DIM_WIDTH-1:0] DIM_TWO = DIM_WIDTH'(2);

  state_t                 state_q;
  logic [DIM_WIDTH-1:0]   width_q, height_q;
  logic [DIM_WIDTH-1:0]   row_q, col_q, col_d;
  logic                   frame_done_q, cfg_err_q;
  logic                   valid_q;
  logic [9*DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0]  win_q [WIN_DIM][WIN_DIM-1];
  logic [DATA_WIDTH-1:0]  new_col [WIN_DIM];
  logic [NUM_LINES-1:0][DATA_WIDTH-1:0] lb_rd;

  logic accept, last_col, last_row, emit, dims_ok;

  assign pix_ready = (state_q == ST_RUN) && (!valid_q || win_ready);
  assign accept    = pix_valid && pix_ready;
  assign last_col  = (col_q == (width_q - DIM_ONE));
  assign last_row  = (row_q == (height_q - DIM_ONE));
  // Columns 0/1 still hold the previous row's tail in the shift window; they never emit.
  assign emit      = accept && (row_q >= DIM_TWO) && (col_q >= DIM_TWO);
  assign dims_ok   = dims_legal(32'(img_width), 32'(img_height),
                                32'(MAX_WIDTH), (32'd1 << DIM_WIDTH) - 32'd1);

  assign MAC_data_in       = data_q;
  assign MAC_data_valid_in = valid_q;
  assign frame_done        = frame_done_q;
  assign cfg_err           = cfg_err_q;

  // Next column; also the line-buffer read address, so the synchronous read
  // data for the next pixel's column is ready when that pixel arrives.
  always_comb begin
    col_d = col_q;
    if (state_q == ST_IDLE && frame_start && dims_ok) begin
      col_d = '0;
    end else if (accept) begin
      col_d = last_col ? '0 : (col_q + DIM_ONE);
    end
  end

  line_buffer_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_LINES  (NUM_LINES)
  ) u_line_buf (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (col_q[ADDR_WIDTH-1:0]),
    .wdata_i (pix_in),
    .raddr_i (col_d[ADDR_WIDTH-1:0]),
    .rdata_o (lb_rd)
  );

  // Newest column of the window, top (row r-2) to bottom (row r).
  always_comb begin
    new_col[0] = lb_rd[1];
    new_col[1] = lb_rd[0];
    new_col[2] = pix_in;
  end

  // Window including the pixel being accepted, packed row-major, byte 0 top-left.
  always_comb begin
    data_d = '0;
    for (int i = 0; i < WIN_DIM; i++) begin
      data_d[(WIN_DIM*i+0)*DATA_WIDTH +: DATA_WIDTH] = win_q[i][0];
      data_d[(WIN_DIM*i+1)*DATA_WIDTH +: DATA_WIDTH] = win_q[i][1];
      data_d[(WIN_DIM*i+2)*DATA_WIDTH +: DATA_WIDTH] = new_col[i];
    end
  end

  // Frame control: dimension latch, raster counters and the pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      width_q      <= '0;
      height_q     <= '0;
      row_q        <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      col_q        <= col_d;
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            if (dims_ok) begin
              width_q  <= img_width;
              height_q <= img_height;
              row_q    <= '0;
              state_q  <= ST_RUN;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept && last_col) begin
            row_q <= row_q + DIM_ONE;
            if (last_row) begin
              state_q <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (!valid_q || win_ready) begin
            state_q      <= ST_IDLE;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Shift window and output register; a new window may replace one that is being accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      for (int i = 0; i < WIN_DIM; i++) begin
        for (int j = 0; j < WIN_DIM - 1; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      if (accept) begin
        for (int i = 0; i < WIN_DIM; i++) begin
          win_q[i][0] <= win_q[i][1];
          win_q[i][1] <= new_col[i];
        end
      end
      if (emit) begin
        data_q  <= data_d;
        valid_q <= 1'b1;
      end else if (win_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_gen
// Description : Self-checking bench for conv_window_gen: dimension table,
//               frame sequences with back-pressure, mid-frame reset and
//               ignored restart, checked against a pixel-index window model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [8:0]  img_width = '0;
  logic [8:0]  img_height = '0;
  logic [7:0]  pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        win_ready = 1'b1;
  logic        pix_ready;
  logic [71:0] MAC_data_in;
  logic        MAC_data_valid_in;
  logic        frame_done;
  logic        cfg_err;

  conv_window_gen #(
    .DATA_WIDTH (8),
    .MAX_WIDTH  (256),
    .DIM_WIDTH  (9)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .frame_start       (frame_start),
    .img_width         (img_width),
    .img_height        (img_height),
    .pix_in            (pix_in),
    .pix_valid         (pix_valid),
    .pix_ready         (pix_ready),
    .MAC_data_in       (MAC_data_in),
    .MAC_data_valid_in (MAC_data_valid_in),
    .win_ready         (win_ready),
    .frame_done        (frame_done),
    .cfg_err           (cfg_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [71:0] exp_q [$];
  logic [71:0] mon_exp;
  logic [71:0] hold_data;
  bit          hold_pending = 1'b0;
  int          m_w = 4, m_row = 0, m_col = 0;
  int          acc_cnt = 0, pops_frame = 0, done_cnt = 0, cfg_cnt = 0;

  typedef struct {
    int w;
    int h;
    bit exp_err;
  } cfg_vec_t;

  cfg_vec_t cv [6];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pixel value at (r,c) is its raster index mod 256; byte k = row k/3, col k%3.
  function automatic logic [71:0] exp_win(input int w, input int r, input int c);
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        v[(3*i+j)*8 +: 8] = 8'(((r - 2 + i) * w + (c - 2 + j)) % 256);
      end
    end
    return v;
  endfunction

  // Monitor: compares windows on handshake, checks holds, predicts windows on pixel accept.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("held_valid", 72'(MAC_data_valid_in), 72'(1));
        check("held_data", MAC_data_in, hold_data);
      end
      if (MAC_data_valid_in && win_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_window_queue_size", 72'(exp_q.size()), 72'(1));
        end else begin
          mon_exp = exp_q.pop_front();
          check("window", MAC_data_in, mon_exp);
        end
        pops_frame++;
      end
      if (MAC_data_valid_in && !win_ready) begin
        check("stall_pix_ready", 72'(pix_ready), 72'(0));
        hold_pending = 1'b1;
        hold_data    = MAC_data_in;
      end else begin
        hold_pending = 1'b0;
      end
      if (pix_valid && pix_ready) begin
        if (m_row >= 2 && m_col >= 2) exp_q.push_back(exp_win(m_w, m_row, m_col));
        if (m_col == m_w - 1) begin
          m_col = 0;
          m_row++;
        end else begin
          m_col++;
        end
        acc_cnt++;
      end
      if (frame_done) begin
        done_cnt++;
        check("done_after_last_window", 72'(exp_q.size()), 72'(0));
      end
      if (cfg_err) cfg_cnt++;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    frame_start = 1'b0;
    pix_valid = 1'b0;
    win_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pix_ready", 72'(pix_ready), 72'(0));
    check("rst_valid", 72'(MAC_data_valid_in), 72'(0));
    check("rst_data", MAC_data_in, 72'(0));
    check("rst_frame_done", 72'(frame_done), 72'(0));
    check("rst_cfg_err", 72'(cfg_err), 72'(0));
    rst = 1'b0;
  endtask

  // mode 0: plain, 1: stall the second window 3 cycles, 2: frame_start mid-run,
  // 3: random valid/ready. rst_at >= 0 resets once that many pixels are accepted.
  task automatic run_frame(input int w, input int h, input int mode, input int rst_at);
    int cyc;
    int stall_cnt;
    int cfg_before;
    bit injected;
    cyc = 0;
    stall_cnt = 0;
    injected = 1'b0;
    m_w = w;
    m_row = 0;
    m_col = 0;
    acc_cnt = 0;
    pops_frame = 0;
    done_cnt = 0;
    cfg_before = cfg_cnt;
    @(posedge clk);
    #1;
    frame_start = 1'b1;
    img_width = 9'(w);
    img_height = 9'(h);
    pix_valid = 1'b0;
    win_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    while (done_cnt == 0 && cyc < 4 * w * h + 100) begin
      if (rst_at >= 0 && acc_cnt == rst_at) begin
        check("pre_reset_valid", 72'(MAC_data_valid_in), 72'(1));
        rst = 1'b1;
        pix_valid = 1'b0;
        #1;
        check("async_rst_valid", 72'(MAC_data_valid_in), 72'(0));
        check("async_rst_data", MAC_data_in, 72'(0));
        check("async_rst_pix_ready", 72'(pix_ready), 72'(0));
        check("async_rst_frame_done", 72'(frame_done), 72'(0));
        check("async_rst_cfg_err", 72'(cfg_err), 72'(0));
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      pix_valid = (acc_cnt < w * h);
      if (mode == 3) pix_valid = pix_valid && ($urandom_range(0, 3) != 0);
      pix_in = 8'(acc_cnt % 256);
      if (mode == 2 && !injected && acc_cnt == 2 * w) begin
        frame_start = 1'b1;
        img_width = 9'd3;
        img_height = 9'd3;
        injected = 1'b1;
      end else begin
        frame_start = 1'b0;
      end
      if (mode == 1 && MAC_data_valid_in && pops_frame == 1 && stall_cnt < 3) begin
        win_ready = 1'b0;
        stall_cnt++;
      end else if (mode == 3) begin
        win_ready = ($urandom_range(0, 2) != 0);
      end else begin
        win_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    pix_valid = 1'b0;
    frame_start = 1'b0;
    win_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("frame_done_count", 72'(done_cnt), 72'(1));
    check("window_count", 72'(pops_frame), 72'((w - 2) * (h - 2)));
    check("pixel_count", 72'(acc_cnt), 72'(w * h));
    check("queue_empty", 72'(exp_q.size()), 72'(0));
    check("cfg_err_quiet", 72'(cfg_cnt - cfg_before), 72'(0));
    if (mode == 1) check("stall_cycles", 72'(stall_cnt), 72'(3));
  endtask

  initial begin
    cv[0] = '{2, 4, 1'b1};
    cv[1] = '{257, 4, 1'b1};
    cv[2] = '{4, 2, 1'b1};
    cv[3] = '{0, 0, 1'b1};
    cv[4] = '{256, 3, 1'b0};
    cv[5] = '{3, 511, 1'b0};

    do_reset();

    for (int i = 0; i < 6; i++) begin
      do_reset();
      frame_start = 1'b1;
      img_width = 9'(cv[i].w);
      img_height = 9'(cv[i].h);
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      check("cfg_err", 72'(cfg_err), 72'(cv[i].exp_err));
      check("cfg_pix_ready", 72'(pix_ready), 72'(!cv[i].exp_err));
      @(posedge clk);
      #1;
      check("cfg_err_pulse_width", 72'(cfg_err), 72'(0));
      check("cfg_pix_ready_hold", 72'(pix_ready), 72'(!cv[i].exp_err));
    end

    do_reset();
    run_frame(4, 4, 0, -1);
    run_frame(4, 4, 1, -1);
    run_frame(256, 3, 0, -1);
    run_frame(4, 4, 0, 11);
    run_frame(4, 4, 0, -1);
    run_frame(4, 4, 2, -1);
    run_frame(7, 5, 3, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
